// File: rtl/muldiv_unit_if.sv
// Handshake and register-file write-port bundle between issue logic and muldiv_unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [1:0]       op;
  logic [2:0]       rd_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             we;
  logic [2:0]       write_reg;
  logic [WIDTH-1:0] write_data;

  modport master (
    output start, op, rd_in, a, b,
    input  busy, done, we, write_reg, write_data
  );

  modport slave (
    input  start, op, rd_in, a, b,
    output busy, done, we, write_reg, write_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit feeding the register-file write port.
// Optional build macro MULDIV_FASTZERO_EN: zero-operand operations bypass RUN.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// RUN   | one shift-add / shift-subtract iteration per cycle, WIDTH cycles
// DONE  | result valid, done (and we if rd != 0) high for one cycle
module muldiv_unit #(
  parameter int WIDTH = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e             state_q;
  logic [1:0]         op_q;
  logic [2:0]         rd_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   opb_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic               busy_q;
  logic               done_q;
  logic               we_q;
  logic [2:0]         wreg_q;
  logic [WIDTH-1:0]   wdata_q;

  logic [WIDTH:0]     mul_sum_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH+1:0]   rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic [WIDTH:0]     rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic [WIDTH-1:0]   result_d;

  always_comb begin
    mul_sum_d = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opb_q} : '0);
    prod_d    = {mul_sum_d, prod_q[WIDTH-1:1]};

    // Restoring step; a zero divisor always subtracts, giving all-ones quotient and remainder = a.
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    rem_diff = rem_sh[WIDTH:0] - {1'b0, opb_q};
    if (rem_sh >= {2'b00, opb_q}) begin
      rem_d = rem_diff;
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = rem_sh[WIDTH:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end

    case (op_q)
      OP_MUL:   result_d = prod_d[WIDTH-1:0];
      OP_MULHU: result_d = prod_d[2*WIDTH-1:WIDTH];
      OP_DIVU:  result_d = quo_d;
      OP_REMU:  result_d = rem_d[WIDTH-1:0];
      default:  result_d = '0;
    endcase
  end

`ifdef MULDIV_FASTZERO_EN
  logic             fast_zero;
  logic [WIDTH-1:0] fast_result;

  always_comb begin
    fast_zero   = 1'b0;
    fast_result = '0;
    if (bus.op == OP_DIVU || bus.op == OP_REMU) begin
      fast_zero   = (bus.b == '0);
      fast_result = (bus.op == OP_DIVU) ? '1 : bus.a;
    end else begin
      fast_zero   = (bus.a == '0) || (bus.b == '0);
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      opb_q   <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            rd_q   <= bus.rd_in;
            opb_q  <= bus.b;
            prod_q <= {{WIDTH{1'b0}}, bus.a};
            quo_q  <= bus.a;
            rem_q  <= '0;
            cnt_q  <= CW'(WIDTH - 1);
            busy_q <= 1'b1;
`ifdef MULDIV_FASTZERO_EN
            if (fast_zero) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              we_q    <= (bus.rd_in != 3'd0);
              wreg_q  <= bus.rd_in;
              wdata_q <= fast_result;
            end else begin
              state_q <= S_RUN;
            end
`else
            state_q <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          prod_q <= prod_d;
          rem_q  <= rem_d;
          quo_q  <= quo_d;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            we_q    <= (rd_q != 3'd0);
            wreg_q  <= rd_q;
            wdata_q <= result_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.we         = we_q;
  assign bus.write_reg  = wreg_q;
  assign bus.write_data = wdata_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors plus randomized ops
// against an arithmetic reference model.
module tb_muldiv_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  muldiv_unit_if #(.WIDTH(8)) bus ();

  muldiv_unit #(.WIDTH(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_result(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int unsigned p;
    p = int'(a) * int'(b);
    case (op)
      2'b00:   return 8'(p % 256);
      2'b01:   return 8'(p / 256);
      2'b10:   return (b == 0) ? 8'hFF : 8'(a / b);
      default: return (b == 0) ? a : 8'(a % b);
    endcase
  endfunction

  // Edges counted from the start edge (inclusive) until done is visible.
  function automatic int ref_latency(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
`ifdef MULDIV_FASTZERO_EN
    if (op[1] && b == 0) return 1;
    if (!op[1] && (a == 0 || b == 0)) return 1;
`endif
    return 9;
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input logic [2:0] rd,
                       output int lat, output logic [7:0] wd, output logic [2:0] wr, output logic wen,
                       output logic seen, output logic tail);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.rd_in = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = 8'($urandom); bus.b = 8'($urandom); bus.op = 2'($urandom); bus.rd_in = 3'($urandom);
    lat = 1; seen = 1'b0; wd = '0; wr = '0; wen = 1'b0; tail = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1; wd = bus.write_data; wr = bus.write_reg; wen = bus.we;
      end else begin
        @(posedge clk);
        lat++;
      end
    end
    if (seen) begin
      @(negedge clk);
      tail = bus.done | bus.we | bus.busy | (bus.write_data !== wd) | (bus.write_reg !== wr);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.we, bus.write_reg, bus.write_data} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b we=%b reg=%0d data=%h want all zero",
               bus.busy, bus.done, bus.we, bus.write_reg, bus.write_data);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_directed;
    logic [1:0] ops [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b00, 2'b01};
    logic [7:0] as  [8] = '{8'd13, 8'd200, 8'd200, 8'd200, 8'h55, 8'h55, 8'd3, 8'd0};
    logic [7:0] bs  [8] = '{8'd11, 8'd200, 8'd7, 8'd7, 8'd0, 8'd0, 8'd4, 8'd9};
    logic [2:0] rds [8] = '{3'd3, 3'd5, 3'd1, 3'd6, 3'd7, 3'd2, 3'd0, 3'd4};
    logic [7:0] exp [8] = '{8'h8F, 8'h9C, 8'h1C, 8'h04, 8'hFF, 8'h55, 8'h0C, 8'h00};
    int lat; logic [7:0] wd; logic [2:0] wr; logic wen, seen, tail;
    for (int i = 0; i < 8; i++) begin
      do_op(ops[i], as[i], bs[i], rds[i], lat, wd, wr, wen, seen, tail);
      checks++;
      if (!seen) begin
        failures++;
        $display("FAIL dir%0d_timeout got no done want done", i);
      end else begin
        if (wd !== exp[i]) begin
          failures++;
          $display("FAIL dir%0d_data got %h want %h", i, wd, exp[i]);
        end
        checks++;
        if (wr !== rds[i] || wen !== (rds[i] != 0)) begin
          failures++;
          $display("FAIL dir%0d_wport got reg=%0d we=%b want reg=%0d we=%b", i, wr, wen, rds[i], rds[i] != 0);
        end
        checks++;
        if (lat !== ref_latency(ops[i], as[i], bs[i])) begin
          failures++;
          $display("FAIL dir%0d_latency got %0d want %0d", i, lat, ref_latency(ops[i], as[i], bs[i]));
        end
        checks++;
        if (tail !== 1'b0) begin
          failures++;
          $display("FAIL dir%0d_one_cycle got tail=%b want 0", i, tail);
        end
      end
    end
  endtask

  task automatic test_random;
    int lat; logic [7:0] wd; logic [2:0] wr; logic wen, seen, tail;
    logic [1:0] op; logic [7:0] a, b; logic [2:0] rd;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      b  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      rd = 3'($urandom);
      do_op(op, a, b, rd, lat, wd, wr, wen, seen, tail);
      checks++;
      if (!seen || wd !== ref_result(op, a, b) || wr !== rd || wen !== (rd != 0)
          || lat !== ref_latency(op, a, b) || tail !== 1'b0) begin
        failures++;
        $display("FAIL rand%0d op=%0d a=%h b=%h got seen=%b data=%h reg=%0d we=%b lat=%0d tail=%b want data=%h reg=%0d we=%b lat=%0d",
                 i, op, a, b, seen, wd, wr, wen, lat, tail, ref_result(op, a, b), rd, rd != 0, ref_latency(op, a, b));
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic seen; logic [7:0] wd; logic [2:0] wr;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 8'd13; bus.b = 8'd11; bus.rd_in = 3'd3;
    @(posedge clk);
    lat = 1; seen = 1'b0; wd = '0; wr = '0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1; wd = bus.write_data; wr = bus.write_reg;
      end else begin
        bus.a = 8'($urandom); bus.b = 8'($urandom); bus.op = 2'($urandom); bus.rd_in = 3'($urandom);
        @(posedge clk);
        lat++;
      end
    end
    checks++;
    if (!seen || lat !== 9 || wd !== 8'h8F || wr !== 3'd3) begin
      failures++;
      $display("FAIL b2b_first got seen=%b lat=%0d data=%h reg=%0d want 9 8f 3", seen, lat, wd, wr);
    end
    bus.op = 2'b10; bus.a = 8'd200; bus.b = 8'd7; bus.rd_in = 3'd2;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 1; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1; wd = bus.write_data; wr = bus.write_reg;
      end else begin
        @(posedge clk);
        lat++;
      end
    end
    checks++;
    if (!seen || lat !== 9 || wd !== 8'h1C || wr !== 3'd2) begin
      failures++;
      $display("FAIL b2b_second got seen=%b lat=%0d data=%h reg=%0d want 9 1c 2", seen, lat, wd, wr);
    end
  endtask

  task automatic test_reset_abort;
    int lat; logic [7:0] wd; logic [2:0] wr; logic wen, seen, tail, bad;
    do_op(2'b00, 8'd13, 8'd11, 3'd3, lat, wd, wr, wen, seen, tail);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 8'd200; bus.b = 8'd7; bus.rd_in = 3'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.we, bus.write_reg, bus.write_data} !== 14'd0) begin
      failures++;
      $display("FAIL abort_outputs got busy=%b done=%b we=%b reg=%0d data=%h want all zero",
               bus.busy, bus.done, bus.we, bus.write_reg, bus.write_data);
    end
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bad = bad | bus.done | bus.we | bus.busy;
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL abort_quiet got activity=%b want 0", bad);
    end
    do_op(2'b10, 8'd200, 8'd7, 3'd4, lat, wd, wr, wen, seen, tail);
    checks++;
    if (!seen || wd !== 8'h1C || wr !== 3'd4 || wen !== 1'b1 || lat !== 9) begin
      failures++;
      $display("FAIL abort_restart got seen=%b data=%h reg=%0d we=%b lat=%0d want 1c 4 1 9", seen, wd, wr, wen, lat);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.rd_in = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
